// File: rtl/io_bus_pkg.sv
// Shared constants and types for the memory-mapped I/O controller.
package io_bus_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'hFFFF_0000;
    localparam int          MAX_BANKS     = 8;
    localparam int          DB_CNT_W      = 20;

    // Byte offsets inside the 128-byte window.
    localparam logic [6:0] OFF_LED = 7'h00;
    localparam logic [6:0] OFF_SW  = 7'h20;
    localparam logic [6:0] OFF_BTN = 7'h40;
    localparam logic [6:0] OFF_EVT = 7'h44;
    localparam logic [6:0] OFF_SEG = 7'h48;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_SW,
        REG_BTN,
        REG_EVT,
        REG_SEG
    } reg_kind_e;

    function automatic logic [4:0] word_idx(input logic [6:0] byte_off);
        return byte_off[6:2];
    endfunction

endpackage

// File: rtl/io_bus_ctrl_btn_debounce.sv
// One button: 2-flop synchroniser, stable level and a one-cycle rise pulse.
// With IO_BTN_DEBOUNCE_EN defined a change must persist DB_CYCLES cycles.
module btn_debounce
    import io_bus_pkg::*;
#(
    parameter logic [DB_CNT_W-1:0] DB_CYCLES = 20'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic rise
);

    if (DB_CYCLES < 20'd2) begin : g_db_check
        $error("btn_debounce: DB_CYCLES must be at least 2");
    end

    logic sync1;
    logic sync2;
    logic level_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

`ifdef IO_BTN_DEBOUNCE_EN
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CYCLES - 20'd1;

    logic [DB_CNT_W-1:0] cnt;
    logic                level_q;

    // Any return to the stable level restarts the run from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            level_q <= 1'b0;
        end else if (sync2 == level_q) begin
            cnt <= '0;
        end else if (cnt == DB_LAST) begin
            cnt     <= '0;
            level_q <= sync2;
        end else begin
            cnt <= cnt + 20'd1;
        end
    end

    assign level = level_q;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O window: LED banks, switch banks, buttons, press events, 7-segment value.
// Define IO_BTN_DEBOUNCE_EN to enable per-button debounce counters.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter logic [31:0]         BASE_ADDR = DEF_BASE_ADDR,
    parameter int                  N_LED     = 2,
    parameter int                  N_SW      = 2,
    parameter int                  N_BTN     = 5,
    parameter logic [DB_CNT_W-1:0] DB_CYCLES = 20'd1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic                 io_read,
    input  logic                 io_write,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 io_hit,
    input  logic [8*N_SW-1:0]    switch_in,
    input  logic [N_BTN-1:0]     button_in,
    output logic [8*N_LED-1:0]   led_out,
    output logic [31:0]          seg_out
);

    if (N_LED < 1 || N_LED > MAX_BANKS || N_SW < 1 || N_SW > MAX_BANKS ||
        N_BTN < 1 || N_BTN > 32) begin : g_param_check
        $error("io_bus_ctrl: bank or button count out of range");
    end

    localparam logic [4:0] W_LED = word_idx(OFF_LED);
    localparam logic [4:0] W_SW  = word_idx(OFF_SW);
    localparam logic [4:0] W_BTN = word_idx(OFF_BTN);
    localparam logic [4:0] W_EVT = word_idx(OFF_EVT);
    localparam logic [4:0] W_SEG = word_idx(OFF_SEG);

    logic [4:0]  off;
    logic [2:0]  bank;
    logic        in_win;
    logic        addr_unused;
    reg_kind_e   kind;

    assign off         = addr[6:2];
    assign bank        = off[2:0];
    assign in_win      = (addr[31:7] == BASE_ADDR[31:7]);
    assign addr_unused = ^addr[1:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        kind = REG_NONE;
        if (in_win) begin
            if (off[4:3] == W_LED[4:3] && int'(bank) < N_LED) begin
                kind = REG_LED;
            end else if (off[4:3] == W_SW[4:3] && int'(bank) < N_SW) begin
                kind = REG_SW;
            end else if (off == W_BTN) begin
                kind = REG_BTN;
            end else if (off == W_EVT) begin
                kind = REG_EVT;
            end else if (off == W_SEG) begin
                kind = REG_SEG;
            end
        end
    end

    assign io_hit = (kind != REG_NONE);

    logic [7:0]          led_q [N_LED];
    logic [31:0]         seg_q;
    logic [8*N_SW-1:0]   sw_s1;
    logic [8*N_SW-1:0]   sw_s2;
    logic [N_BTN-1:0]    btn_level;
    logic [N_BTN-1:0]    btn_rise;
    logic [N_BTN-1:0]    evt_q;
    logic                evt_clr;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .button (button_in[i]),
            .level  (btn_level[i]),
            .rise   (btn_rise[i])
        );
    end

    assign evt_clr = io_read && (kind == REG_EVT);

    // NOTE: the LED bank array is a handful of output flops, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_LED; k++) begin
                led_q[k] <= '0;
            end
            seg_q <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
            evt_q <= '0;
        end else begin
            if (io_write && kind == REG_LED) begin
                for (int k = 0; k < N_LED; k++) begin
                    if (bank == 3'(k)) begin
                        led_q[k] <= wdata[7:0];
                    end
                end
            end
            if (io_write && kind == REG_SEG) begin
                seg_q <= wdata;
            end
            sw_s1 <= switch_in;
            sw_s2 <= sw_s1;
            // A press landing on the clearing read survives: set wins over clear.
            evt_q <= (evt_clr ? '0 : evt_q) | btn_rise;
        end
    end

    for (genvar k = 0; k < N_LED; k++) begin : g_led
        assign led_out[8*k +: 8] = led_q[k];
    end
    assign seg_out = seg_q;

    always_comb begin
        rdata = '0;
        if (io_read) begin
            case (kind)
                REG_LED: begin
                    for (int k = 0; k < N_LED; k++) begin
                        if (bank == 3'(k)) rdata = 32'(led_q[k]);
                    end
                end
                REG_SW: begin
                    for (int k = 0; k < N_SW; k++) begin
                        if (bank == 3'(k)) rdata = 32'(sw_s2[8*k +: 8]);
                    end
                end
                REG_BTN: rdata = 32'(btn_level);
                REG_EVT: rdata = 32'(evt_q);
                REG_SEG: rdata = seg_q;
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/io_bus_ctrl.md
# io_bus_ctrl

Parametrised memory-mapped I/O controller between the CPU data path and board peripherals. It decodes a word-addressed I/O window, drives banked LEDs and the 7-segment value register, and returns synchronised switch data, debounced button levels and sticky button-press events. Its read data feeds the register-file writeback mux alongside DMem read data. Compared with the previous I/O block, it adds registered outputs with readback, input synchronisers, debounce, and clear-on-read press events.

## Interface
- `BASE_ADDR`, 32'hFFFF0000, window base; window is `BASE_ADDR` + 0x00..0x7F.
- `N_LED`, 2, number of 8-bit LED banks (1..8).
- `N_SW`, 2, number of 8-bit switch banks (1..8).
- `N_BTN`, 5, number of buttons (1..32).
- `DB_CYCLES`, 20'd1000000, consecutive stable cycles required to accept a button change (≥2).
- `clk` in 1, system clock; all state changes on rising edge.
- `rst` in 1, reset, asynchronous, active-low.
- `addr` in 32, byte address from ALU result.
- `io_read` in 1, I/O read strobe from controller.
- `io_write` in 1, I/O write strobe from controller.
- `wdata` in 32, store data from register file.
- `rdata` out 32, read data to writeback mux.
- `io_hit` out 1, `addr` decodes to a mapped register.
- `switch_in` in 8*N_SW, raw switch pins; bank k is bits [8k+7:8k].
- `button_in` in N_BTN, raw button pins, active-high.
- `led_out` out 8*N_LED, LED pins; bank k is bits [8k+7:8k].
- `seg_out` out 32, value to 7-segment display driver.

## Operation
- Decode: `addr[1:0]` ignored. Offset `off = addr[6:2]` (word index). In-window when `addr[31:7] == BASE_ADDR[31:7]`.
- Map (byte offsets):
  - 0x00+4k LED bank k, R/W, k<N_LED.
  - 0x20+4k switch bank k, RO, k<N_SW.
  - 0x40 button stable level, RO.
  - 0x44 button press events, R / clear-on-read.
  - 0x48 seg, R/W.
- `io_hit` = 1 for mapped offsets only. Unmapped or out-of-window accesses: writes ignored, `rdata` = 0.
- Write: if `io_write && io_hit` at a clock edge, the target register takes `wdata`. LED banks take `wdata[7:0]`; seg takes all 32 bits. Writes to RO registers are ignored.
- Read: `rdata` is combinational from registered state whenever `io_read && io_hit`, else 0.
  - Banks are zero-extended to 32 bits.
  - LED and seg reads return the current register value.
- Input path: `switch_in` and `button_in` each pass through a 2-flop synchroniser.
- Debounce, per button:
  - Counter resets to 0 whenever the synced input equals the stable level.
  - Otherwise it increments each cycle.
  - On reaching DB_CYCLES−1, the stable level takes the synced value and the counter clears.
- Events: bit i sets on a stable-level 0→1 transition of button i. All bits clear at the edge where `io_read` is asserted at offset 0x44.
- Simultaneous event set and clear on the same edge: set wins, so the bit stays 1.
- Simultaneous `io_read` and `io_write` to the same R/W register: `rdata` returns the pre-write value; the write takes effect at the edge.

## Timing
- Reset (async assert, sync release through flops): `led_out`=0, `seg_out`=0, synchronisers=0, stable levels=0, counters=0, events=0.
- Combinational outputs during reset: `rdata`=0 unless a read decodes (then it returns reset values); `io_hit` follows `addr`.
- Write latency: `led_out`/`seg_out` update at the first rising edge with `io_write` and are visible the next cycle.
- Read latency: 0 cycles (same-cycle combinational).
- Switch latency: 2 cycles from pin to readable value.
- Button latency: 2 sync cycles + DB_CYCLES cycles of stability; event visible the cycle after the stable level rises.
- A bounce (synced input returning to the stable level) restarts the count from 0.
- Reset mid-debounce discards the count; no event is generated.

## Configuration
- `IO_BTN_DEBOUNCE_EN` defined: debounce counters present as described.
- Not defined: no counters. The stable level equals the synchronised input (2-cycle latency), and events fire on synced 0→1 edges. `DB_CYCLES` is unused.

## Structure
- Package `io_bus_pkg`:
  - offset constants `OFF_LED`=0x00, `OFF_SW`=0x20, `OFF_BTN`=0x40, `OFF_EVT`=0x44, `OFF_SEG`=0x48;
  - default `BASE_ADDR`;
  - max bank count 8.
- Sub-module `btn_debounce`: one button, holding its synchroniser, counter and stable level and producing a rise pulse. Instantiated N_BTN times via generate.
- Top level holds decode, LED/seg registers, event register and the read mux.

## Test plan
- Reset: hold `rst`=0 → `led_out`=0, `seg_out`=0; read 0x44 returns 0.
- LED/seg write: write 0x000000A5 to 0xFFFF0004 → `led_out[15:8]`=0xA5 next cycle, read-back 0xA5. Write 0x12345678 to 0xFFFF0048 → `seg_out`=0x12345678.
- Switches: `switch_in`=0x3C81 → after 2 cycles, read 0xFFFF0020 = 0x81 and read 0xFFFF0024 = 0x3C.
- Debounce (DB_CYCLES=4): button 2 toggles high for 3 cycles → no change. Hold high 6 cycles → 0x40 reads 0x4, 0x44 reads 0x4; a second 0x44 read returns 0.
- Set/clear collision: a press event arrives on the same edge as a 0x44 read → the bit remains 1 afterwards.
- Unmapped access: write to 0xFFFF0060 and 0xFFFE0000 → `io_hit`=0, outputs unchanged, `rdata`=0.
